booth_mult: RTL and testbench

- Multi-cycle signed radix-2 Booth multiplier for MULT/MULTU.
- Inverse counterpart of the CPU's restoring divider; shares its start/stop handshake and its HI/LO result convention.
- Sits beside the divider in the execute stage. The control unit pulses MultIn and waits on MultStop. resultHigh/resultLow feed the HI/LO register write.

---
 rtl/mult_pkg.sv | 28 ++
 rtl/booth_step.sv | 36 +++
 rtl/booth_mult.sv | 121 ++++++++++++
 tb/tb_booth_mult.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared types and constants for the radix-2 Booth multiplier.
//   MULT_WIDTH : default operand width
//   ITER       : Booth iterations for the default width (WIDTH+1)
//   state_e    : controller states IDLE / RUN / DONE
//   op_e       : per-iteration Booth operation NOP / ADD / SUB
package mult_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int ITER       = MULT_WIDTH + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  typedef enum logic [1:0] {NOP = 2'd0, ADD = 2'd1, SUB = 2'd2} op_e;

  // One iteration per multiplier bit plus one for the extension bit of Q.
  function automatic int iter_count(input int w);
    return w + 1;
  endfunction

  // Booth recoding of the pair {Q[0], q_1}.
  function automatic op_e booth_op(input logic [1:0] pair);
    case (pair)
      2'b01:   return ADD;
      2'b10:   return SUB;
      default: return NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_step.sv
// booth_step: one combinational radix-2 Booth iteration.
//   i_acc / i_q / i_q1 : current {ACC, Q, q_1}
//   i_m                : extended multiplicand
//   o_acc / o_q / o_q1 : {ACC, Q, q_1} after add/sub and arithmetic shift right
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [WIDTH+1:0] i_acc,
  input  logic [WIDTH:0]   i_q,
  input  logic             i_q1,
  input  logic [WIDTH+1:0] i_m,
  output logic [WIDTH+1:0] o_acc,
  output logic [WIDTH:0]   o_q,
  output logic             o_q1
);

  logic [WIDTH+1:0] w_sum;

  // Add/sub wraps modulo 2^(WIDTH+2); the guard bits keep the result exact.
  always_comb begin
    w_sum = i_acc;
    case (booth_op({i_q[0], i_q1}))
      ADD:     w_sum = i_acc + i_m;
      SUB:     w_sum = i_acc - i_m;
      default: w_sum = i_acc;
    endcase
  end

  // Arithmetic shift of {ACC, Q, q_1}: ACC MSB replicates, ACC LSB enters Q.
  assign o_acc = {w_sum[WIDTH+1], w_sum[WIDTH+1:1]};
  assign o_q   = {w_sum[0], i_q[WIDTH:1]};
  assign o_q1  = i_q[0];

endmodule

// File: rtl/booth_mult.sv
// booth_mult: multi-cycle radix-2 Booth multiplier (MULT, optionally MULTU).
//   clk        : rising-edge clock
//   Reset      : asynchronous active-low reset
//   A, B       : multiplicand / multiplier, sampled on the start edge
//   MultIn     : start request, honoured only in IDLE
//   MultU      : (MULT_UNSIGNED_EN builds only) 1 = zero-extend operands
//   MultBusy   : high in RUN and DONE
//   MultStop   : one-cycle completion pulse
//   resultHigh : product bits [2*WIDTH-1:WIDTH]
//   resultLow  : product bits [WIDTH-1:0]
// Build option: define MULT_UNSIGNED_EN to add the MultU port.
module booth_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             Reset,
`ifdef MULT_UNSIGNED_EN
  input  logic             MultU,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             MultIn,
  output logic             MultBusy,
  output logic             MultStop,
  output logic [WIDTH-1:0] resultHigh,
  output logic [WIDTH-1:0] resultLow
);

  localparam int ITER_N = iter_count(WIDTH);
  localparam int CW     = $clog2(ITER_N + 1);

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH+1:0] r_m;
  logic [WIDTH+1:0] r_acc;
  logic [WIDTH:0]   r_q;
  logic             r_q1;
  logic             r_busy;
  logic             r_stop;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_sx;
  logic [WIDTH+1:0] w_acc_n;
  logic [WIDTH:0]   w_q_n;
  logic             w_q1_n;

  // Sign-extension enable for the operands.
`ifdef MULT_UNSIGNED_EN
  assign w_sx = ~MultU;
`else
  assign w_sx = 1'b1;
`endif

  booth_step #(.WIDTH(WIDTH)) u_step (
    .i_acc (r_acc),
    .i_q   (r_q),
    .i_q1  (r_q1),
    .i_m   (r_m),
    .o_acc (w_acc_n),
    .o_q   (w_q_n),
    .o_q1  (w_q1_n)
  );

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_m     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_q1    <= 1'b0;
      r_busy  <= 1'b0;
      r_stop  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (MultIn) begin
            r_m     <= {{2{w_sx & A[WIDTH-1]}}, A};
            r_acc   <= '0;
            r_q     <= {w_sx & B[WIDTH-1], B};
            r_q1    <= 1'b0;
            r_cnt   <= CW'(ITER_N);
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc <= w_acc_n;
          r_q   <= w_q_n;
          r_q1  <= w_q1_n;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            // Low 2*WIDTH bits of the post-shift {ACC, Q}: Q holds bits
            // [WIDTH:0], ACC[WIDTH-2:0] holds bits [2*WIDTH-1:WIDTH+1].
            r_hi    <= {w_acc_n[WIDTH-2:0], w_q_n[WIDTH]};
            r_lo    <= w_q_n[WIDTH-1:0];
            r_stop  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_stop  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign MultBusy   = r_busy;
  assign MultStop   = r_stop;
  assign resultHigh = r_hi;
  assign resultLow  = r_lo;

endmodule

// File: tb/tb_booth_mult.sv
module tb_booth_mult;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         Reset = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         MultIn = 1'b0;
  logic         MultBusy, MultStop;
  logic [W-1:0] resultHigh, resultLow;
`ifdef MULT_UNSIGNED_EN
  logic         MultU = 1'b0;
`endif

  int n_chk = 0;
  int n_fail = 0;

  booth_mult #(.WIDTH(W)) dut (
    .clk        (clk),
    .Reset      (Reset),
`ifdef MULT_UNSIGNED_EN
    .MultU      (MultU),
`endif
    .A          (A),
    .B          (B),
    .MultIn     (MultIn),
    .MultBusy   (MultBusy),
    .MultStop   (MultStop),
    .resultHigh (resultHigh),
    .resultLow  (resultLow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         u;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 2*W-bit product of the extended operands.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic u);
    logic [2*W-1:0] ea, eb;
    ea = u ? {{W{1'b0}}, a} : {{W{a[W-1]}}, a};
    eb = u ? {{W{1'b0}}, b} : {{W{b[W-1]}}, b};
    return ea * eb;
  endfunction

  // Runs one operation from a negedge; optionally injects an ignored start
  // at t10 with new operands, toggled again afterwards.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic u, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input bit disturb, input bit timing);
    int stops, first, busy_cnt;
    stops = 0; first = -1; busy_cnt = 0;
    @(negedge clk);
    A = a; B = b; MultIn = 1'b1;
`ifdef MULT_UNSIGNED_EN
    MultU = u;
`endif
    @(negedge clk);  // start edge t0 has passed
    MultIn = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (MultStop) begin
        stops++;
        if (first < 0) first = k;
      end
      if (MultBusy) busy_cnt++;
      if (disturb && k == 9) begin
        MultIn = 1'b1; A = 32'd9; B = 32'd9;
      end
      if (disturb && k == 10) begin
        MultIn = 1'b0; A = ~A; B = ~B;
      end
      @(negedge clk);
    end
    if (timing) begin
      chk({name, " stop_cycle"}, 64'(first), 64'd33);
      chk({name, " busy_cycles"}, 64'(busy_cnt), 64'd34);
    end
    chk({name, " stop_count"}, 64'(stops), 64'd1);
    chk({name, " hi"}, 64'(resultHigh), 64'(ehi));
    chk({name, " lo"}, 64'(resultLow), 64'(elo));
  endtask

  initial begin
    vec_t vt[$];
    logic [2*W-1:0] p;
    logic [W-1:0] ra, rb;
    logic ru;
    int stops;

    // Reset state
    #3;
    chk("rst busy", 64'(MultBusy), 64'd0);
    chk("rst stop", 64'(MultStop), 64'd0);
    chk("rst hi", 64'(resultHigh), 64'd0);
    chk("rst lo", 64'(resultLow), 64'd0);
    repeat (2) @(negedge clk);
    Reset = 1'b1;

    vt.push_back('{32'd3, 32'd5, 1'b0, 32'h0, 32'hF});
    vt.push_back('{32'd7, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB});
    vt.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h1});
    vt.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h0});
    vt.push_back('{32'h0, 32'h12345678, 1'b0, 32'h0, 32'h0});
    vt.push_back('{32'h7FFFFFFF, 32'h80000000, 1'b0, 32'hC0000000, 32'h80000000});
`ifdef MULT_UNSIGNED_EN
    vt.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h1});
    vt.push_back('{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h0});
    vt.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h1});
`endif
    foreach (vt[i])
      run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].u, vt[i].hi, vt[i].lo,
             1'b0, i == 0);

    // Start ignored while RUN; operand changes after t0 ignored.
    run_op("ignore_start", 32'd3, 32'd5, 1'b0, 32'h0, 32'hF, 1'b1, 1'b1);

    // Random operands against the reference product.
    for (int i = 0; i < 16; i++) begin
      ra = $urandom; rb = $urandom;
`ifdef MULT_UNSIGNED_EN
      ru = 1'($urandom_range(0, 1));
`else
      ru = 1'b0;
`endif
      p = model(ra, rb, ru);
      run_op($sformatf("rand%0d", i), ra, rb, ru, p[2*W-1:W], p[W-1:0], 1'b0, 1'b0);
    end

    // Asynchronous reset mid-operation.
    @(negedge clk);
    A = 32'h10001; B = 32'h30003; MultIn = 1'b1;
    @(negedge clk);
    MultIn = 1'b0;
    repeat (12) @(posedge clk);
    #3 Reset = 1'b0;
    #1;
    chk("midrst busy", 64'(MultBusy), 64'd0);
    chk("midrst stop", 64'(MultStop), 64'd0);
    chk("midrst hi", 64'(resultHigh), 64'd0);
    chk("midrst lo", 64'(resultLow), 64'd0);
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    stops = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (MultStop) stops++;
    end
    chk("midrst no_stop", 64'(stops), 64'd0);
    chk("midrst idle_busy", 64'(MultBusy), 64'd0);
    run_op("after_rst", 32'd2, 32'd4, 1'b0, 32'h0, 32'h8, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
